// File: rtl/ooo_pkg.sv
// Shared out-of-order front-end definitions: FU codes, bundle sizes, dispatch FSM states.
package ooo_pkg;

  localparam int FuCodeSize   = 3;
  localparam int PayloadWidth = 302;

  localparam logic [FuCodeSize-1:0] FU_ALU = 3'd0;
  localparam logic [FuCodeSize-1:0] FU_LSU = 3'd1;
  localparam logic [FuCodeSize-1:0] FU_BRU = 3'd2;
  localparam logic [FuCodeSize-1:0] FU_FPU = 3'd3;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_HOLD    = 2'd2
  } disp_state_e;

endpackage

// File: rtl/rs_credit_counter.sv
// Saturating up/down credit counter for one reservation station; flags a return at full.
module rs_credit_counter #(
  parameter int Depth = 8,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic            ovf_o
);

  logic [CntW-1:0] count_q, count_d;
  logic            full;

  assign full = (count_q == CntW'(Depth));

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full) count_d = count_q + 1'b1;
    else if (dec_i && !inc_i)     count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) count_q <= CntW'(Depth);
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign ovf_o   = inc_i && full;

endmodule

// File: rtl/inorder_dispatch.sv
// In-order dispatch: pops the instruction queue and steers each bundle to its RS under credit control.
// Optional INORDER_DISPATCH_STATS_EN adds dispatch / stall-cycle counters.
module inorder_dispatch #(
  parameter int NumRS        = 4,
  parameter int RSDepth      = 8,
  parameter int FuCodeSize   = ooo_pkg::FuCodeSize,
  parameter int PayloadWidth = ooo_pkg::PayloadWidth
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    qEmpty_i,
  output logic                    qReadEnable_o,
  input  logic [FuCodeSize-1:0]   qFuType_i,
  input  logic [PayloadWidth-1:0] qPayload_i,
  input  logic                    flush_i,
  output logic [NumRS-1:0]        rsValid_o,
  output logic [PayloadWidth-1:0] rsPayload_o,
  input  logic [NumRS-1:0]        rsCreditReturn_i,
  output logic                    errIllegalFu_o,
`ifdef INORDER_DISPATCH_STATS_EN
  output logic                    errCreditOvf_o,
  output logic [31:0]             statDispatched_o,
  output logic [31:0]             statStallCycles_o
`else
  output logic                    errCreditOvf_o
`endif
);
  import ooo_pkg::*;

  localparam int CntW = $clog2(RSDepth + 1);

  disp_state_e                  state_q, state_d;
  logic [FuCodeSize-1:0]        hold_fu_q, hold_fu_d;
  logic [PayloadWidth-1:0]      hold_pl_q, hold_pl_d;
  logic [NumRS-1:0][CntW-1:0]   credit;
  logic [NumRS-1:0]             ovf, fire_vec;
  logic [FuCodeSize-1:0]        src_fu;
  logic [PayloadWidth-1:0]      src_pl;
  logic                         active, legal, fire, drop, pop;
  logic                         err_ill_q, err_ovf_q;

  // PENDING bypasses straight from the queue outputs; HOLD replays the captured copy.
  always_comb begin
    src_fu   = (state_q == ST_HOLD) ? hold_fu_q : qFuType_i;
    src_pl   = (state_q == ST_HOLD) ? hold_pl_q : qPayload_i;
    active   = (state_q != ST_EMPTY);
    legal    = 1'b0;
    fire_vec = '0;
    for (int k = 0; k < NumRS; k++) begin
      if (src_fu == FuCodeSize'(k)) begin
        legal       = 1'b1;
        fire_vec[k] = active && !flush_i && (credit[k] != '0);
      end
    end
    fire = |fire_vec;
    drop = active && !flush_i && !legal;
    pop  = !reset_i && !qEmpty_i && !flush_i && (!active || fire || drop);
  end

  always_comb begin
    state_d   = state_q;
    hold_fu_d = hold_fu_q;
    hold_pl_d = hold_pl_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (!active || fire || drop) begin
      state_d = pop ? ST_PENDING : ST_EMPTY;
    end else if (state_q == ST_PENDING) begin
      state_d   = ST_HOLD;
      hold_fu_d = qFuType_i;
      hold_pl_d = qPayload_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_EMPTY;
      hold_fu_q <= '0;
      hold_pl_q <= '0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_fu_q <= hold_fu_d;
      hold_pl_q <= hold_pl_d;
      err_ill_q <= err_ill_q | drop;
      err_ovf_q <= err_ovf_q | (|ovf);
    end
  end

  for (genvar k = 0; k < NumRS; k++) begin : g_rs
    rs_credit_counter #(.Depth(RSDepth), .CntW(CntW)) u_credit (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .inc_i   (rsCreditReturn_i[k]),
      .dec_i   (fire_vec[k]),
      .count_o (credit[k]),
      .ovf_o   (ovf[k])
    );
  end

  assign qReadEnable_o  = pop;
  assign rsValid_o      = fire_vec;
  assign rsPayload_o    = active ? src_pl : '0;
  assign errIllegalFu_o = err_ill_q;
  assign errCreditOvf_o = err_ovf_q;

`ifdef INORDER_DISPATCH_STATS_EN
  logic [31:0] stat_disp_q, stat_stall_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stat_disp_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_disp_q  <= stat_disp_q + 32'(fire);
      stat_stall_q <= stat_stall_q + 32'((state_q == ST_HOLD) && !fire);
    end
  end

  assign statDispatched_o  = stat_disp_q;
  assign statStallCycles_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_inorder_dispatch.sv
// Randomized bench for inorder_dispatch against an in-flight-instruction / credit-pool reference model.
module tb_inorder_dispatch;
  import ooo_pkg::*;

  localparam int NRS = 4;
  localparam int DEP = 8;
  localparam int FW  = FuCodeSize;
  localparam int PW  = PayloadWidth;

  logic           clock_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           qEmpty_i = 1'b1;
  logic           qReadEnable_o;
  logic [FW-1:0]  qFuType_i = '0;
  logic [PW-1:0]  qPayload_i = '0;
  logic           flush_i = 1'b0;
  logic [NRS-1:0] rsValid_o;
  logic [PW-1:0]  rsPayload_o;
  logic [NRS-1:0] rsCreditReturn_i = '0;
  logic           errIllegalFu_o;
  logic           errCreditOvf_o;
`ifdef INORDER_DISPATCH_STATS_EN
  logic [31:0]    statDispatched_o, statStallCycles_o;
`endif

  inorder_dispatch #(.NumRS(NRS), .RSDepth(DEP), .FuCodeSize(FW), .PayloadWidth(PW)) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .qEmpty_i         (qEmpty_i),
    .qReadEnable_o    (qReadEnable_o),
    .qFuType_i        (qFuType_i),
    .qPayload_i       (qPayload_i),
    .flush_i          (flush_i),
    .rsValid_o        (rsValid_o),
    .rsPayload_o      (rsPayload_o),
    .rsCreditReturn_i (rsCreditReturn_i),
    .errIllegalFu_o   (errIllegalFu_o),
`ifdef INORDER_DISPATCH_STATS_EN
    .errCreditOvf_o   (errCreditOvf_o),
    .statDispatched_o (statDispatched_o),
    .statStallCycles_o(statStallCycles_o)
`else
    .errCreditOvf_o   (errCreditOvf_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [FW-1:0] fu;
    logic [PW-1:0] pl;
  } instr_t;

  instr_t tbq[$];

  // Reference: at most one instruction in flight, a pool of credits per RS, sticky flags.
  bit            m_inf;
  instr_t        m_ins;
  int            m_age;
  int            m_cred[NRS];
  bit            m_eill, m_eovf;
  int            m_ndisp, m_nstall;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] rand_pl();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom();
    return t[PW-1:0];
  endfunction

  task automatic push(input int fu);
    instr_t it;
    it.fu = FW'(fu);
    it.pl = rand_pl();
    tbq.push_back(it);
  endtask

  task automatic model_reset();
    m_inf = 0; m_age = 0; m_eill = 0; m_eovf = 0; m_ndisp = 0; m_nstall = 0;
    for (int k = 0; k < NRS; k++) m_cred[k] = DEP;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    flush_i = 1'b0;
    rsCreditReturn_i = '0;
    tbq.delete();
    qEmpty_i = 1'b1;
    model_reset();
    #2;
    chk("rst_valid",   PW'(rsValid_o), '0);
    chk("rst_pop",     PW'(qReadEnable_o), '0);
    chk("rst_payload", rsPayload_o, '0);
    chk("rst_eill",    PW'(errIllegalFu_o), '0);
    chk("rst_eovf",    PW'(errCreditOvf_o), '0);
`ifdef INORDER_DISPATCH_STATS_EN
    chk("rst_sdisp",   PW'(statDispatched_o), '0);
    chk("rst_sstall",  PW'(statStallCycles_o), '0);
`endif
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
  endtask

  // One clock: caller sets flush_i / rsCreditReturn_i beforehand; called at posedge+1.
  task automatic cycle();
    bit ef, ed, ep, popped;
    logic [NRS-1:0] ev;
    instr_t it;
    qEmpty_i = (tbq.size() == 0);
    @(negedge clock_i);
    ef = 0; ed = 0; ev = '0; popped = 0;
    if (m_inf && !flush_i) begin
      if (int'(m_ins.fu) < NRS) begin
        if (m_cred[m_ins.fu] > 0) begin
          ef = 1;
          ev[m_ins.fu] = 1'b1;
        end
      end else ed = 1;
    end
    ep = (tbq.size() > 0) && !flush_i && (!m_inf || ef || ed);
    chk("rs_valid", PW'(rsValid_o), PW'(ev));
    chk("q_pop", PW'(qReadEnable_o), PW'(ep));
    if (ef) chk("rs_payload", rsPayload_o, m_ins.pl);
    chk("err_illegal", PW'(errIllegalFu_o), PW'(m_eill));
    chk("err_ovf", PW'(errCreditOvf_o), PW'(m_eovf));
`ifdef INORDER_DISPATCH_STATS_EN
    chk("stat_disp", PW'(statDispatched_o), PW'(m_ndisp));
    chk("stat_stall", PW'(statStallCycles_o), PW'(m_nstall));
`endif
    if (ef) m_ndisp++;
    if (m_inf && m_age > 0 && !ef) m_nstall++;
    for (int k = 0; k < NRS; k++) begin
      int f;
      f = (ef && int'(m_ins.fu) == k) ? 1 : 0;
      if (rsCreditReturn_i[k] && m_cred[k] == DEP) m_eovf = 1;
      m_cred[k] = m_cred[k] + int'(rsCreditReturn_i[k]) - f;
      if (m_cred[k] > DEP) m_cred[k] = DEP;
    end
    if (ed) m_eill = 1;
    if (flush_i) begin
      m_inf = 0;
    end else if (!m_inf || ef || ed) begin
      m_inf = 0;
      if (ep) begin
        it = tbq.pop_front();
        m_ins = it; m_inf = 1; m_age = 0; popped = 1;
      end
    end else begin
      m_age++;
    end
    @(posedge clock_i);
    #1;
    if (popped) begin
      qFuType_i  = it.fu;
      qPayload_i = it.pl;
    end else begin
      qFuType_i  = FW'($urandom());
      qPayload_i = rand_pl();
    end
    flush_i = 1'b0;
    rsCreditReturn_i = '0;
  endtask

  initial begin
    do_reset();

    // back-to-back dispatch to three stations
    push(FU_ALU); push(FU_LSU); push(FU_BRU);
    repeat (6) cycle();

    // exhaust RS0, 9th stalls until one return
    do_reset();
    repeat (9) push(FU_ALU);
    repeat (14) cycle();
    rsCreditReturn_i[0] = 1'b1;
    cycle();
    repeat (3) cycle();

    // fire to RS1 coincident with an RS1 return
    repeat (4) push(FU_LSU);
    cycle(); cycle();
    rsCreditReturn_i[1] = 1'b1;
    cycle();
    repeat (4) cycle();

    // illegal FU code dropped, next one goes through
    push(5); push(FU_LSU);
    repeat (5) cycle();

    // flush while holding
    do_reset();
    repeat (9) push(FU_FPU);
    repeat (14) cycle();
    flush_i = 1'b1;
    cycle();
    repeat (2) cycle();
    push(FU_FPU);
    repeat (3) cycle();
    rsCreditReturn_i[3] = 1'b1;
    repeat (3) cycle();

    // return at full credit
    do_reset();
    rsCreditReturn_i[2] = 1'b1;
    cycle();
    repeat (2) cycle();

    // random traffic, with one reset in the middle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (tbq.size() < 6 && $urandom_range(1, 0) == 1)
        push(($urandom_range(15, 0) == 0) ? $urandom_range(7, 4) : $urandom_range(3, 0));
      for (int k = 0; k < NRS; k++)
        if (m_cred[k] < DEP && $urandom_range(2, 0) == 0) rsCreditReturn_i[k] = 1'b1;
      if ($urandom_range(49, 0) == 0) flush_i = 1'b1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/inorder_dispatch.md
# inorder_dispatch

Dispatch stage directly downstream of the in-order instruction queue. Pops one decoded instruction at a time from the queue, then steers it to one of `NumRS` reservation stations selected by its functional-unit code. Per-station credit counters mirror free RS slots, so an instruction is only presented where it can be accepted. A one-entry hold register absorbs stalls while keeping one-instruction-per-cycle throughput when no station is full.

## Interface
Parameters:
- `NumRS`, 4: number of reservation stations; FU code k targets RS k.
- `RSDepth`, 8: entries per RS; reset value of every credit counter.
- `FuCodeSize`, 3: width of the functional-unit code.
- `PayloadWidth`, 302: concatenated instruction bundle (format, opcode, address, IDs, pid/tid, operand info, body).

Ports:
- Clock and reset: one clock, `clock_i`; reset `reset_i` is asynchronous and active-high.
- `clock_i`  in  1  clock.
- `reset_i`  in  1  async active-high reset.
- `qEmpty_i`  in  1  queue empty flag.
- `qReadEnable_o`  out  1  pop request; queue data is valid on the inputs the following cycle.
- `qFuType_i`  in  FuCodeSize  FU code of the popped instruction.
- `qPayload_i`  in  PayloadWidth  popped instruction bundle.
- `flush_i`  in  1  discard any instruction in flight; suppress pops.
- `rsValid_o`  out  NumRS  one-hot; write strobe to the target RS.
- `rsPayload_o`  out  PayloadWidth  bundle to all RS.
- `rsCreditReturn_i`  in  NumRS  per-RS pulse, one slot freed.
- `errIllegalFu_o`  out  1  sticky; FU code ≥ NumRS was seen.
- `errCreditOvf_o`  out  1  sticky; credit return arrived while a counter was at RSDepth.

## Operation
- Three-state FSM:
  - EMPTY: nothing in flight.
  - PENDING: pop issued last cycle; data is on `q*_i`.
  - HOLD: the instruction sits in the hold register.
- Source selection: instruction source is `q*_i` in PENDING (bypass) and the hold register in HOLD. `rsPayload_o` is muxed from the same source.
- fire: asserted in PENDING/HOLD when `credit[fu] > 0`, fu < NumRS, and `!flush_i`. It drives `rsValid_o[fu]=1`, combinationally from state, hold, and credits.
- Illegal FU code: sets `errIllegalFu_o` and drops the instruction (treated as fire with `rsValid_o=0`).
- Pop rule: `qReadEnable_o = !qEmpty_i && !flush_i && (state==EMPTY || fire || illegal drop)`. At most one instruction is ever in flight.
- Transitions:
  - EMPTY → PENDING on pop, else stay in EMPTY.
  - PENDING/HOLD on fire or drop: → PENDING if pop, else → EMPTY.
  - PENDING without fire: capture `q*_i` into hold → HOLD.
  - HOLD without fire: stay in HOLD.
- flush_i: in any state the next state is EMPTY, with no `rsValid_o` and no pop that cycle. Data returned by an earlier pop is ignored. Credits are untouched; the RS returns its own credits.
- Credits, per k:
  - Update: `credit[k] += rsCreditReturn_i[k] - (fire to k)`; a simultaneous decrement and return leaves the count unchanged.
  - Counter width is clog2(RSDepth+1).
  - A return at RSDepth saturates and sets `errCreditOvf_o`.
  - A decrement at 0 cannot occur, because fire requires credit > 0.

## Timing
- Reset values:
  - State EMPTY; hold register 0.
  - `credit[k]=RSDepth`.
  - `qReadEnable_o=0`, `rsValid_o=0`, `rsPayload_o=0`, both error flags 0, stats 0.
- Latency: pop at cycle t; RS write strobe at t+1 if credit is available (bypass). A stalled instruction fires the first cycle credit appears.
- Throughput: 1 instruction/cycle sustained with non-empty queue and credits available.
- A credit return in cycle t is usable for fire in t+1, not in t.
- Reset asserted mid-operation clears everything immediately; an in-flight instruction is lost.

## Configuration
- `INORDER_DISPATCH_STATS_EN`:
  - Defined: adds outputs `statDispatched_o` (32, count of fires) and `statStallCycles_o` (32, cycles in HOLD without fire). Both counters wrap and reset to 0.
  - Undefined: the ports and counters are absent.

## Structure
- The shared package `ooo_pkg` holds:
  - FU code constants (`FU_ALU=0`, `FU_LSU=1`, `FU_BRU=2`, `FU_FPU=3`)
  - `FuCodeSize`
  - `PayloadWidth`
  - the FSM state typedef.
- One sub-module, `rs_credit_counter`: a single saturating up/down counter with overflow flag, instantiated NumRS times.

## Test plan
- Reset, queue holding 3 instructions with FU 0,1,2 → pops at cycles 0,1,2; `rsValid_o` = 0001, 0010, 0100 at cycles 1,2,3; credits become 7 each.
- 9 instructions with FU 0 and no returns → 8 dispatched; 9th enters HOLD. A return pulse at cycle n → fire at n+1, credit[0] stays 0.
- Simultaneous fire to RS1 and `rsCreditReturn_i[1]` → credit[1] unchanged.
- FU code 5 → no `rsValid_o`, `errIllegalFu_o`=1 sticky, next instruction dispatched normally.
- `flush_i` while in HOLD → no strobe, EMPTY next cycle, no pop during flush; credits unchanged.
- Return to RS2 at full credit → stays 8, `errCreditOvf_o`=1. With the macro defined, after 4 fires plus 2 stall cycles → stats read 4 and 2.
